layer_train_sequencer: RTL and testbench
========================================

LAYER_TRAIN_SEQUENCER -- requirements
Module: layer_train_sequencer

Interface
REQ-001 SHALL have parameter N, default 16: input count of the sequenced neuron layer.
REQ-002 SHALL have parameter M, default 33: neuron count of the layer.
REQ-003 SHALL have parameter FWD_LAT, default 2: cycles from layer_valid to a stable layer_out; legal range 1..15.
REQ-004 SHALL have parameter LEARN_CYC, default 1: cycles learn is held; legal range 1..15.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports s_valid (input, 1) and s_ready (output, 1): sample handshake.
REQ-008 SHALL have port s_in, input, zero2one_t[N]: sample input vector.
REQ-009 SHALL have port s_expected, input, zero2one_t[M]: target output vector.
REQ-010 SHALL have port s_train, input, 1 bit: a learn phase is requested for this sample.
REQ-011 SHALL have ports layer_valid and layer_learn, output, 1 bit each: drive the layer's valid and learn inputs.
REQ-012 SHALL have ports layer_in (output, zero2one_t[N]) and layer_expected (output, zero2one_t[M]): held sample registers.
REQ-013 SHALL have port layer_out, input, zero2one_t[M]: the layer's output.
REQ-014 SHALL have ports r_valid (output, 1), r_ready (input, 1) and r_out (output, zero2one_t[M]): result handshake.
REQ-015 SHALL have port sample_cnt, output, 16 bits: count of completed samples.
REQ-016 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-017 SHALL have port err_sum, output, $bits(zero2one_t)+6 bits: summed absolute error of the last sample.

Function
REQ-018 SHALL implement the states IDLE, FWD, WAIT, LEARN and RESULT.
REQ-019 SHALL drive s_ready=1 only in IDLE; on s_valid&&s_ready it captures s_in, s_expected and s_train, then goes to FWD.
REQ-020 SHALL, in FWD, assert layer_valid for exactly one cycle, load the counter with FWD_LAT-1 and go to WAIT.
REQ-021 SHALL, in WAIT, decrement the counter; at 0, capture layer_out into r_out, then go to LEARN if s_train was captured high, otherwise to RESULT.
REQ-022 SHALL, in LEARN, hold layer_valid=1 and layer_learn=1 for LEARN_CYC cycles, then go to RESULT.
REQ-023 SHALL keep layer_learn=0 in every state other than LEARN.
REQ-024 SHALL, in RESULT, hold r_valid=1 with r_out stable until r_ready=1.
REQ-025 SHALL, on the r_ready handshake, increment sample_cnt (wrapping 0xFFFF->0) and return to IDLE; no new sample is accepted in the same cycle.
REQ-026 SHALL give a sample without training a latency of FWD_LAT+2 cycles from acceptance to r_valid; a training sample adds LEARN_CYC cycles.
REQ-027 SHALL ignore s_valid and s_in changes while not in IDLE.
REQ-028 SHALL hold layer_in and layer_expected constant from capture until the next capture.

Reset
REQ-029 SHALL, on reset assertion, immediately force state=IDLE, layer_valid=0, layer_learn=0, r_valid=0, sample_cnt=0, err_sum=0, r_out=0, layer_in=0 and layer_expected=0.
REQ-030 SHALL, on reset mid-sample (including during LEARN), drop layer_learn in the same instant and not count the sample.

Configuration
REQ-031 SHALL, with macro TRAIN_SEQ_ERR_EN defined, set err_sum at the WAIT capture to the sum over M of |layer_out[i]-layer_expected[i]|, unsigned and without overflow.
REQ-032 SHALL, without TRAIN_SEQ_ERR_EN, keep the err_sum port present and tied to 0, and synthesise no subtractors.

Structure
REQ-033 SHALL place the train_seq_state_t enum and the ERR_W=$bits(zero2one_t)+6 constant in the shared package; zero2one_t stays in defs.svh.
REQ-034 SHALL isolate the error reduction in one sub-module, abs_err_sum, instantiated only under TRAIN_SEQ_ERR_EN.

Verification
REQ-035 SHALL cover: FWD_LAT=2, one s_train=0 sample -> one layer_valid pulse, r_valid 4 cycles after acceptance, layer_learn never 1.
REQ-036 SHALL cover: s_train=1 with LEARN_CYC=3 -> layer_learn high exactly 3 cycles after the WAIT capture, then r_valid.
REQ-037 SHALL cover: r_ready held 0 for 10 cycles -> r_out stable, s_ready=0, sample_cnt unchanged; r_ready=1 -> sample_cnt+1, s_ready the next cycle.
REQ-038 SHALL cover: reset asserted during LEARN -> layer_learn=0 asynchronously, state IDLE, sample_cnt=0.
REQ-039 SHALL cover: with TRAIN_SEQ_ERR_EN, layer_out all max and expected all 0 -> err_sum=33*max; without the macro, err_sum=0.
REQ-040 SHALL cover: sample_cnt preloaded to 0xFFFF via 65535 samples, then one more handshake -> sample_cnt=0.

Source files
------------

// File: rtl/layer_train_sequencer_pkg.sv
// Package for the layer train sequencer: state encoding and error width.
// The error accumulator width leaves 6 bits of headroom above one element,
// enough for a layer of up to 64 neurons to sum without overflow.
package layer_train_sequencer_pkg;
   `include "defs.svh"

   localparam int ERR_W = $bits(zero2one_t) + 6;

   typedef enum logic [2:0] {
      IDLE,
      FWD,
      WAIT,
      LEARN,
      RESULT
   } train_seq_state_t;
endpackage

// File: rtl/defs.svh
// Shared scalar types for the neuron layer datapath.
// zero2one_t is an unsigned fixed-point value covering 0.0 .. 1.0.
`ifndef DEFS_SVH
`define DEFS_SVH
typedef logic [7:0] zero2one_t;
`endif

// File: rtl/layer_train_sequencer_abs_err_sum.sv
// abs_err_sum: sum over all neurons of |a - b|, unsigned.
// Only compiled when TRAIN_SEQ_ERR_EN is defined; the default build
// carries no subtractors at all.
`ifdef TRAIN_SEQ_ERR_EN
module abs_err_sum
   import layer_train_sequencer_pkg::*;
#(
   parameter int M = 33
) (
   input  zero2one_t [M-1:0] a_i,
   input  zero2one_t [M-1:0] b_i,
   output logic [ERR_W-1:0]  sum_o
);

   // Accumulate the magnitude of each element difference, ordering the operands so it never wraps
   always_comb begin
      sum_o = '0;
      for (int i = 0; i < M; i++) begin
         if (a_i[i] >= b_i[i]) begin
            sum_o = sum_o + ERR_W'(a_i[i] - b_i[i]);
         end else begin
            sum_o = sum_o + ERR_W'(b_i[i] - a_i[i]);
         end
      end
   end

endmodule
`endif

// File: rtl/layer_train_sequencer.sv
// layer_train_sequencer: feeds one sample at a time into a neuron layer,
// waits out the forward latency, optionally holds the learn phase, and
// presents the layer output on a result handshake.
// Optional feature: define TRAIN_SEQ_ERR_EN to compute err_sum; otherwise
// err_sum is tied to zero.
module layer_train_sequencer
   import layer_train_sequencer_pkg::*;
#(
   parameter int N         = 16,
   parameter int M         = 33,
   parameter int FWD_LAT   = 2,
   parameter int LEARN_CYC = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  zero2one_t [N-1:0] s_in,
   input  zero2one_t [M-1:0] s_expected,
   input  logic              s_train,
   output logic              layer_valid,
   output logic              layer_learn,
   output zero2one_t [N-1:0] layer_in,
   output zero2one_t [M-1:0] layer_expected,
   input  zero2one_t [M-1:0] layer_out,
   output logic              r_valid,
   input  logic              r_ready,
   output zero2one_t [M-1:0] r_out,
   output logic [15:0]       sample_cnt,
   output logic              busy,
   output logic [ERR_W-1:0]  err_sum
);

   localparam logic [3:0] FWD_LOAD   = 4'(FWD_LAT - 1);
   localparam logic [3:0] LEARN_LOAD = 4'(LEARN_CYC - 1);

   train_seq_state_t  state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              train_q;
   zero2one_t [N-1:0] layerIn_q;
   zero2one_t [M-1:0] layerExp_q;
   zero2one_t [M-1:0] rOut_q;
   logic [15:0]       sampleCnt_q;
   logic              acceptSample;
   logic              captureResult;
   logic              resultTaken;

   // Next-state and handshake decode; layer strobes come straight from the state so reset drops them at once
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      acceptSample  = 1'b0;
      captureResult = 1'b0;
      resultTaken   = 1'b0;
      s_ready       = 1'b0;
      layer_valid   = 1'b0;
      layer_learn   = 1'b0;
      r_valid       = 1'b0;
      case (state_q)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               acceptSample = 1'b1;
               state_d      = FWD;
            end
         end
         FWD: begin
            layer_valid = 1'b1;
            cnt_d       = FWD_LOAD;
            state_d     = WAIT;
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               captureResult = 1'b1;
               if (train_q) begin
                  cnt_d   = LEARN_LOAD;
                  state_d = LEARN;
               end else begin
                  state_d = RESULT;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         LEARN: begin
            layer_valid = 1'b1;
            layer_learn = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = RESULT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESULT: begin
            r_valid = 1'b1;
            if (r_ready) begin
               resultTaken = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, sample capture, result capture and completed-sample counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         train_q     <= 1'b0;
         layerIn_q   <= '0;
         layerExp_q  <= '0;
         rOut_q      <= '0;
         sampleCnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (acceptSample) begin
            layerIn_q  <= s_in;
            layerExp_q <= s_expected;
            train_q    <= s_train;
         end
         if (captureResult) begin
            rOut_q <= layer_out;
         end
         if (resultTaken) begin
            sampleCnt_q <= sampleCnt_q + 16'd1;
         end
      end
   end

   assign layer_in       = layerIn_q;
   assign layer_expected = layerExp_q;
   assign r_out          = rOut_q;
   assign sample_cnt     = sampleCnt_q;
   assign busy           = (state_q != IDLE);

`ifdef TRAIN_SEQ_ERR_EN
   logic [ERR_W-1:0] errNow;
   logic [ERR_W-1:0] errSum_q;

   abs_err_sum #(.M(M)) uAbsErrSum (
      .a_i   (layer_out),
      .b_i   (layerExp_q),
      .sum_o (errNow)
   );

   // Latch the sample error at the same instant the result is captured
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         errSum_q <= '0;
      end else if (captureResult) begin
         errSum_q <= errNow;
      end
   end

   assign err_sum = errSum_q;
`else
   assign err_sum = '0;
`endif

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Self-checking bench for layer_train_sequencer with FWD_LAT=2, LEARN_CYC=3.
// Expected results are queued when a sample is issued; a monitor pops and
// compares them whenever the DUT presents a result.
module tb_layer_train_sequencer;
   import layer_train_sequencer_pkg::*;

   localparam int N         = 16;
   localparam int M         = 33;
   localparam int FWD_LAT   = 2;
   localparam int LEARN_CYC = 3;
   localparam int VW        = M * $bits(zero2one_t);
`ifdef TRAIN_SEQ_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              clock;
   logic              reset;
   logic              s_valid;
   logic              s_ready;
   zero2one_t [N-1:0] s_in;
   zero2one_t [M-1:0] s_expected;
   logic              s_train;
   logic              layer_valid;
   logic              layer_learn;
   zero2one_t [N-1:0] layer_in;
   zero2one_t [M-1:0] layer_expected;
   zero2one_t [M-1:0] layer_out;
   logic              r_valid;
   logic              r_ready;
   zero2one_t [M-1:0] r_out;
   logic [15:0]       sample_cnt;
   logic              busy;
   logic [ERR_W-1:0]  err_sum;

   typedef struct packed {
      logic [VW-1:0]    rOut;
      logic [ERR_W-1:0] err;
      logic [15:0]      cnt;
   } expect_t;

   expect_t     sbQ[$];
   int          checks   = 0;
   int          failures = 0;
   int          fwdPulses;
   int          learnCycles;
   logic [15:0] swCnt;

   layer_train_sequencer #(
      .N(N), .M(M), .FWD_LAT(FWD_LAT), .LEARN_CYC(LEARN_CYC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_in           (s_in),
      .s_expected     (s_expected),
      .s_train        (s_train),
      .layer_valid    (layer_valid),
      .layer_learn    (layer_learn),
      .layer_in       (layer_in),
      .layer_expected (layer_expected),
      .layer_out      (layer_out),
      .r_valid        (r_valid),
      .r_ready        (r_ready),
      .r_out          (r_out),
      .sample_cnt     (sample_cnt),
      .busy           (busy),
      .err_sum        (err_sum)
   );

   // Free-running clock, rising edge active
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: count layer strobes and score every presented result against the queue
   always @(negedge clock) begin
      expect_t e;
      if (!reset) begin
         if (layer_valid && !layer_learn) fwdPulses++;
         if (layer_learn) learnCycles++;
         if (r_valid) begin
            if (sbQ.size() == 0) begin
               checkOutput("sb_unexpected_result", 1, 0);
            end else begin
               checkOutput("r_out", r_out, sbQ[0].rOut);
               if (r_ready) begin
                  e = sbQ.pop_front();
                  checkOutput("err_sum", err_sum, e.err);
                  checkOutput("sample_cnt_at_handshake", sample_cnt, e.cnt);
               end
            end
         end
      end
   end

   // Issue one sample, check timing and held registers, then complete the result handshake
   task automatic applyStimulus(input zero2one_t [N-1:0] inV, input zero2one_t [M-1:0] expV,
                                input logic train, input zero2one_t [M-1:0] outV,
                                input logic [ERR_W-1:0] expErr, input int holdCycles);
      expect_t e;
      int      lat;
      checkOutput("s_ready_idle", s_ready, 1);
      e.rOut = outV;
      e.err  = expErr;
      e.cnt  = swCnt;
      sbQ.push_back(e);
      fwdPulses   = 0;
      learnCycles = 0;
      s_in       = inV;
      s_expected = expV;
      s_train    = train;
      layer_out  = outV;
      s_valid    = 1'b1;
      @(posedge clock); #1;
      s_train    = ~train;
      s_in       = ~inV;
      s_expected = ~expV;
      checkOutput("busy_after_accept", busy, 1);
      lat = 1;
      while (!r_valid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      checkOutput("latency", lat, FWD_LAT + 2 + (train ? LEARN_CYC : 0));
      checkOutput("fwd_pulses", fwdPulses, 1);
      checkOutput("learn_cycles", learnCycles, train ? LEARN_CYC : 0);
      checkOutput("layer_in_held", layer_in, inV);
      checkOutput("layer_expected_held", layer_expected, expV);
      repeat (holdCycles) begin
         @(posedge clock); #1;
         checkOutput("hold_r_valid", r_valid, 1);
         checkOutput("hold_s_ready", s_ready, 0);
         checkOutput("hold_sample_cnt", sample_cnt, swCnt);
      end
      r_ready = 1'b1;
      s_valid = 1'b0;
      @(posedge clock); #1;
      r_ready = 1'b0;
      swCnt   = swCnt + 16'd1;
      checkOutput("cnt_after_handshake", sample_cnt, swCnt);
      checkOutput("s_ready_after_handshake", s_ready, 1);
      checkOutput("r_valid_after_handshake", r_valid, 0);
   endtask

   // Directed sequence: plain, training, backpressure, reset in LEARN, max error, counter wrap
   initial begin
      int                lat;
      zero2one_t [N-1:0] inV;
      zero2one_t [M-1:0] pat;
      clock      = 1'b0;
      reset      = 1'b1;
      s_valid    = 1'b0;
      s_train    = 1'b0;
      s_in       = '0;
      s_expected = '0;
      layer_out  = '0;
      r_ready    = 1'b0;
      swCnt      = '0;
      #12;
      checkOutput("reset_s_ready", s_ready, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_layer_valid", layer_valid, 0);
      checkOutput("reset_layer_learn", layer_learn, 0);
      checkOutput("reset_r_valid", r_valid, 0);
      checkOutput("reset_sample_cnt", sample_cnt, 0);
      checkOutput("reset_err_sum", err_sum, 0);
      checkOutput("reset_r_out", r_out, 0);
      checkOutput("reset_layer_in", layer_in, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < N; i++) inV[i] = zero2one_t'(i + 1);
      $display("[TB] plain sample");
      applyStimulus(inV, {M{8'h10}}, 1'b0, {M{8'h30}}, ERR_EN ? ERR_W'(1056) : '0, 0);

      $display("[TB] training sample");
      applyStimulus({N{8'hC3}}, {M{8'h80}}, 1'b1, {M{8'h20}}, ERR_EN ? ERR_W'(3168) : '0, 0);

      $display("[TB] backpressure sample");
      for (int i = 0; i < M; i++) pat[i] = zero2one_t'(i * 7);
      applyStimulus({N{8'h3C}}, pat, 1'b0, pat, '0, 10);

      $display("[TB] reset during learn");
      s_in       = {N{8'h5A}};
      s_expected = {M{8'h11}};
      s_train    = 1'b1;
      layer_out  = {M{8'h22}};
      s_valid    = 1'b1;
      @(posedge clock); #1;
      s_valid = 1'b0;
      lat = 0;
      while (!layer_learn && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      checkOutput("learn_reached", layer_learn, 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_learn_layer_learn", layer_learn, 0);
      checkOutput("rst_learn_layer_valid", layer_valid, 0);
      checkOutput("rst_learn_busy", busy, 0);
      checkOutput("rst_learn_sample_cnt", sample_cnt, 0);
      checkOutput("rst_learn_r_out", r_out, 0);
      checkOutput("rst_learn_layer_in", layer_in, 0);
      checkOutput("rst_learn_err_sum", err_sum, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      swCnt = '0;

      $display("[TB] maximum error sample");
      applyStimulus({N{8'h01}}, {M{8'h00}}, 1'b0, {M{8'hFF}}, ERR_EN ? ERR_W'(8415) : '0, 0);

      $display("[TB] sample counter wrap");
      force dut.sampleCnt_q = 16'hFFFF;
      @(posedge clock); #1;
      release dut.sampleCnt_q;
      swCnt = 16'hFFFF;
      checkOutput("cnt_preload", sample_cnt, 16'hFFFF);
      applyStimulus({N{8'h77}}, {M{8'h40}}, 1'b0, {M{8'h44}}, ERR_EN ? ERR_W'(132) : '0, 0);
      checkOutput("cnt_wrapped", sample_cnt, 0);

      repeat (2) @(posedge clock);
      checkOutput("sb_drained", sbQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
